pc_fetch_stage: RTL

- Fetch-stage state holder for the 5-stage pipeline.
- Owns the program counter register. PCResult drives instruction memory and the PC+4 adder. The adder's PCAddResult returns here as the sequential next-PC candidate.
- Selects the next PC from sequential, branch and jump sources, and honours hazard-unit stalls.
- Captures the IF/ID pipeline register (PC+4, instruction, valid) and keeps a fetched-instruction counter.

---
 rtl/pc_fetch_stage_if.sv | 36 +++
 rtl/pc_fetch_stage.sv | 86 ++++++++
 2 files changed

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls and the fetch datapath in,
// registered PC and IF/ID pipeline state out.
interface pc_fetch_stage_if;
  // Control and datapath inputs to the fetch stage
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpTaken;
  logic [31:0] JumpTarget;
  logic [31:0] PCAddResult;
  logic [31:0] Instruction;

  // Registered fetch-stage state
  logic [31:0] PCResult;
  logic [31:0] IFID_PCPlus4;
  logic [31:0] IFID_Instruction;
  logic        IFID_Valid;
  logic        AlignFault;
  logic [31:0] FetchCount;

  // Pipeline side: hazard unit, branch/jump resolution, adder, imem
  modport master (
    output Stall, BranchTaken, BranchTarget, JumpTaken, JumpTarget,
           PCAddResult, Instruction,
    input  PCResult, IFID_PCPlus4, IFID_Instruction, IFID_Valid,
           AlignFault, FetchCount
  );

  // Fetch stage itself
  modport slave (
    input  Stall, BranchTaken, BranchTarget, JumpTaken, JumpTarget,
           PCAddResult, Instruction,
    output PCResult, IFID_PCPlus4, IFID_Instruction, IFID_Valid,
           AlignFault, FetchCount
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// Fetch stage: program counter, next-PC selection (branch > jump > stall >
// sequential), IF/ID pipeline register, sticky alignment fault and a
// saturating count of instructions latched valid into IF/ID.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input logic              Clk,
  input logic              Reset,
  pc_fetch_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    SEL_BRANCH,
    SEL_JUMP,
    SEL_HOLD,
    SEL_SEQ
  } sel_e;

  sel_e        sel;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        misaligned;

  // Pick the winning next-PC source; the branch is older than the jump, so it wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    sel             = SEL_SEQ;
    redirect_target = bus.JumpTarget;
    if (bus.BranchTaken) begin
      sel             = SEL_BRANCH;
      redirect_target = bus.BranchTarget;
    end else if (bus.JumpTaken) begin
      sel = SEL_JUMP;
    end else if (bus.Stall) begin
      sel = SEL_HOLD;
    end
  end

  assign redirect   = (sel == SEL_BRANCH) || (sel == SEL_JUMP);
  // Only the winning target is inspected; a losing simultaneous target is ignored.
  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);

  // PC and IF/ID register: redirect flushes, stall holds, otherwise fetch sequentially.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
      bus.PCResult         <= RESET_PC;
      bus.IFID_PCPlus4     <= 32'h0000_0000;
      bus.IFID_Instruction <= NOP_INSTR;
      bus.IFID_Valid       <= 1'b0;
    end else begin
      case (sel)
        SEL_BRANCH, SEL_JUMP: begin
          bus.PCResult         <= {redirect_target[31:2], 2'b00};
          bus.IFID_PCPlus4     <= 32'h0000_0000;
          bus.IFID_Instruction <= NOP_INSTR;
          bus.IFID_Valid       <= 1'b0;
        end
        SEL_SEQ: begin
          bus.PCResult         <= bus.PCAddResult;
          bus.IFID_PCPlus4     <= bus.PCAddResult;
          bus.IFID_Instruction <= bus.Instruction;
          bus.IFID_Valid       <= 1'b1;
        end
        default: ;  // SEL_HOLD: PC and IF/ID keep their values
      endcase
    end
  end

  // Sticky misaligned-redirect flag and saturating fetched-instruction counter.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bus.AlignFault <= 1'b0;
      bus.FetchCount <= 32'h0000_0000;
    end else begin
      if (misaligned) begin
        bus.AlignFault <= 1'b1;
      end
      if (sel == SEL_SEQ && bus.FetchCount != 32'hFFFF_FFFF) begin
        bus.FetchCount <= bus.FetchCount + 32'd1;
      end
    end
  end

endmodule
